gshare_predictor: RTL and testbench
===================================

// Module: gshare_predictor
// PURPOSE
//  Gshare dynamic branch predictor for the CPU fetch stage. Combinationally predicts
//  taken/not-taken for a fetched control-flow instruction from a 256-entry table of
//  2-bit saturating counters. The table index is the branch PC low byte XOR an 8-bit
//  global history register (GHR). Trains on resolved branch outcomes from execute.
// PARAMETERS
//  IDX_W   8          index / history width; PHT depth = 2**IDX_W
//  CTR_RST 2'b01      PHT counter reset value (weakly not-taken)
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      asynchronous active-low reset
//  start           in   1      predict enable; prediction forced 0 when low
//  update          in   1      train strobe; one update per clk edge while high
//  branch_address  in   IDX_W  PC low bits of the instruction being predicted
//  update_address  in   IDX_W  PC low bits of the resolved branch being trained
//  branch_taken    in   1      actual outcome of the resolved branch
//  opcode          in   7      RV32 opcode, qualifies both prediction and update
//  prediction      out  1      1 = predict taken
// BEHAVIOUR
//  - Opcode decode: BR=7'b1100011 (conditional); JAL=7'b1101111, JALR=7'b1100111 (jumps).
//  - prediction (combinational, zero latency):
//    start & (JAL|JALR | (BR & pht[branch_address^ghr][1]))
//    Any other opcode -> 0.
//  - Reset (rst==0, async): ghr=0, every PHT entry=CTR_RST.
//    prediction stays combinational, so it reads the reset table.
//  - Update fires on posedge clk when rst==1 & update==1 & opcode==BR:
//    uidx = update_address ^ ghr (GHR value before this edge);
//    taken: pht[uidx] += 1, saturating at 2'b11;
//    not-taken: pht[uidx] -= 1, saturating at 2'b00;
//    ghr <= {ghr[IDX_W-2:0], branch_taken}. The oldest bit is discarded on wrap.
//  - Jumps, and update with a non-BR opcode: no PHT or GHR change.
//  - Same-cycle predict and update of the same index: prediction uses the pre-edge counter.
//    There is no bypass; the new value is visible the cycle after the edge.
//  - Reset asserted mid-operation clears state immediately; a pending update is dropped.
//  - Index arithmetic is a pure IDX_W-bit XOR with no carries.
// STRUCTURE
//  - Shared package cpu_pkg: OPC_BRANCH, OPC_JAL, OPC_JALR; typedef ctr2_t (2-bit counter).
//  - Optional sub-module sat_counter2: 2-bit up/down saturating counter.
//    It computes the next PHT value from the current value and the taken bit.
//  - PHT is a register array with async reset; it must not infer RAM.
// TESTING
//  1 Reset, start=1, opcode=BR, branch_address=8'd4 -> prediction=0 (counter 01).
//  2 start=1, opcode=JAL (then JALR), any address -> prediction=1;
//    start=0 -> prediction=0; opcode=7'b0110011 -> prediction=0.
//  3 After reset: update=1, opcode=BR, update_address=0, taken=1, one edge.
//    Then pht[0]=10 and ghr=8'h01.
//    Predict with branch_address=8'h01 (idx 0) -> prediction=1.
//  4 Continue from 3: update_address=8'h01, taken=0, one edge.
//    Then pht[0]=01 and ghr=8'h02.
//    Predict with branch_address=8'h02 (idx 0) -> prediction=0.
//  5 Saturation at a fixed index (re-align update_address to ghr each edge):
//    4 taken updates -> counter 11; 1 not-taken -> 10, prediction still 1;
//    4 not-taken -> 00, no underflow.
//  6 Mid-run rst=0 pulse, asynchronous, no clk edge needed -> ghr=0, all entries 01.
//    Predict on BR -> prediction=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcode constants and the 2-bit counter type
package cpu_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef logic [1:0] ctr2_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit up/down saturating counter next-value logic
module sat_counter2
   import cpu_pkg::*;
(
   input  ctr2_t cur,
   input  logic  taken,
   output ctr2_t nxt
);

   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != 2'b11) nxt = cur + 2'b01;
      end else begin
         if (cur != 2'b00) nxt = cur - 2'b01;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor: PC xor global history into a 2-bit counter table
module gshare_predictor
   import cpu_pkg::*;
#(
   parameter int    IDX_W   = 8,
   parameter ctr2_t CTR_RST = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             update,
   input  logic [IDX_W-1:0] branch_address,
   input  logic [IDX_W-1:0] update_address,
   input  logic             branch_taken,
   input  logic [6:0]       opcode,
   output logic             prediction
);

   localparam int DEPTH = 1 << IDX_W;

   ctr2_t            pht [DEPTH];
   logic [IDX_W-1:0] ghr;
   logic [IDX_W-1:0] pidx;
   logic [IDX_W-1:0] uidx;
   ctr2_t            upd_next;
   logic             is_br;
   logic             is_jump;

   assign is_br   = (opcode == OPC_BRANCH);
   assign is_jump = (opcode == OPC_JAL) || (opcode == OPC_JALR);
   assign pidx    = branch_address ^ ghr;
   assign uidx    = update_address ^ ghr;

   // Reads the pre-edge counter; a same-cycle update becomes visible only after the edge.
   assign prediction = start & (is_jump | (is_br & pht[pidx][1]));

   sat_counter2 u_ctr (
      .cur   (pht[uidx]),
      .taken (branch_taken),
      .nxt   (upd_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
         for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_RST;
      end else if (update && is_br) begin
         pht[uidx] <= upd_next;
         ghr       <= {ghr[IDX_W-2:0], branch_taken};
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed self-checking bench for gshare_predictor
module tb_gshare_predictor;
   import cpu_pkg::*;

   localparam logic [6:0] OPC_ALU = 7'b0110011;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       update;
   logic [7:0] branch_address;
   logic [7:0] update_address;
   logic       branch_taken;
   logic [6:0] opcode;
   logic       prediction;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] g;

   gshare_predictor #(.IDX_W(8), .CTR_RST(2'b01)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .update         (update),
      .branch_address (branch_address),
      .update_address (update_address),
      .branch_taken   (branch_taken),
      .opcode         (opcode),
      .prediction     (prediction)
   );

   always #5 clk = ~clk;

   // one branch update aimed at table index idx, model history advanced afterwards
   task automatic br_update(input logic [7:0] idx, input logic tk);
      update_address = idx ^ g;
      branch_taken   = tk;
      opcode         = OPC_BRANCH;
      update         = 1'b1;
      @(posedge clk);
      #1;
      update = 1'b0;
      g = {g[6:0], tk};
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b1; update = 1'b0; opcode = OPC_BRANCH;
      branch_address = 8'd4; update_address = 8'd0; branch_taken = 1'b0;
      #3;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL reset_pred actual=%b required=0", prediction);
      end
      total++;
      if (dut.ghr !== 8'h00) begin
         bad++; $display("FAIL reset_ghr actual=%h required=00", dut.ghr);
      end
      @(negedge clk);
      rst = 1'b1;
      g = 8'h00;
      @(posedge clk);
      #1;
   endtask

   task automatic test_jumps;
      logic [6:0] ops [4] = '{OPC_JAL, OPC_JALR, OPC_JAL, OPC_ALU};
      logic       sts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i]; start = sts[i]; branch_address = 8'hA5 + 8'(i);
         #1;
         total++;
         if (prediction !== exp[i]) begin
            bad++; $display("FAIL jump_pred[%0d] actual=%b required=%b", i, prediction, exp[i]);
         end
      end
      start = 1'b1;
      // updates carrying non-branch opcodes must not train
      opcode = OPC_JAL; update = 1'b1; branch_taken = 1'b1;
      @(posedge clk); #1;
      opcode = OPC_ALU;
      @(posedge clk); #1;
      update = 1'b0;
      total++;
      if (dut.ghr !== 8'h00) begin
         bad++; $display("FAIL nonbr_update_ghr actual=%h required=00", dut.ghr);
      end
   endtask

   task automatic test_train;
      br_update(8'h00, 1'b1);
      total++;
      if (dut.ghr !== 8'h01) begin
         bad++; $display("FAIL train1_ghr actual=%h required=01", dut.ghr);
      end
      opcode = OPC_BRANCH; branch_address = 8'h01; #1;
      total++;
      if (prediction !== 1'b1) begin
         bad++; $display("FAIL train1_pred actual=%b required=1", prediction);
      end
      branch_address = 8'h00; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL train1_other_idx actual=%b required=0", prediction);
      end
      br_update(8'h00, 1'b0);
      total++;
      if (dut.ghr !== 8'h02) begin
         bad++; $display("FAIL train2_ghr actual=%h required=02", dut.ghr);
      end
      branch_address = 8'h02; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL train2_pred actual=%b required=0", prediction);
      end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 4; i++) br_update(8'h00, 1'b1);
      br_update(8'h00, 1'b0);
      opcode = OPC_BRANCH; branch_address = g; #1;
      total++;
      if (prediction !== 1'b1) begin
         bad++; $display("FAIL sat_high_pred actual=%b required=1", prediction);
      end
      total++;
      if (dut.ghr !== 8'h5E) begin
         bad++; $display("FAIL sat_ghr actual=%h required=5e", dut.ghr);
      end
      for (int i = 0; i < 4; i++) br_update(8'h00, 1'b0);
      branch_address = g; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL sat_low_pred actual=%b required=0", prediction);
      end
      total++;
      if (dut.ghr !== 8'hE0) begin
         bad++; $display("FAIL wrap_ghr actual=%h required=e0", dut.ghr);
      end
      // counter now 00; one taken gives 01, still not-taken
      br_update(8'h00, 1'b1);
      branch_address = g; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL sat_floor_pred actual=%b required=0", prediction);
      end
   endtask

   task automatic test_same_cycle;
      // index 0 holds 01: predict and train it together
      opcode = OPC_BRANCH; branch_address = g; update_address = g;
      branch_taken = 1'b1; update = 1'b1; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL same_cycle_pre actual=%b required=0", prediction);
      end
      @(posedge clk); #1;
      update = 1'b0;
      g = {g[6:0], 1'b1};
      branch_address = g; #1;
      total++;
      if (prediction !== 1'b1) begin
         bad++; $display("FAIL same_cycle_post actual=%b required=1", prediction);
      end
   endtask

   task automatic test_async_reset;
      opcode = OPC_BRANCH; update = 1'b1; update_address = g; branch_taken = 1'b1;
      @(negedge clk); #2;
      rst = 1'b0; #1;
      g = 8'h00;
      total++;
      if (dut.ghr !== 8'h00) begin
         bad++; $display("FAIL async_rst_ghr actual=%h required=00", dut.ghr);
      end
      branch_address = 8'h00; #1;
      total++;
      if (prediction !== 1'b0) begin
         bad++; $display("FAIL async_rst_pred actual=%b required=0", prediction);
      end
      @(posedge clk); #1;
      total++;
      if (dut.ghr !== 8'h00) begin
         bad++; $display("FAIL rst_drop_update actual=%h required=00", dut.ghr);
      end
      update = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_jumps();
      test_train();
      test_saturation();
      test_same_cycle();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
